yupferris_bitslam_envdac: RTL and testbench
===========================================

YUPFERRIS_BITSLAM_ENVDAC -- requirements
Module: yupferris_bitslam_envdac

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port tone_in, input, 1 bit: square-wave tone bit from the upstream oscillator, sampled each clk.
REQ-004 SHALL have port wr_en, input, 1 bit: register write strobe, one write per cycle when high.
REQ-005 SHALL have port wr_addr, input, 6 bits: register address.
REQ-006 SHALL have port wr_data, input, 6 bits: register write data.
REQ-007 SHALL have port pdm_out, output, 1 bit: registered sigma-delta bitstream for the chip pin.
REQ-008 SHALL have port env_level, output, 6 bits: current envelope value.
REQ-009 SHALL have port env_state, output, 2 bits: current FSM state encoding.

Function
REQ-010 SHALL implement registers: addr 0x01 VOLUME[5:0], addr 0x02 RATE[5:0], addr 0x03 CTRL (bit0 TRIGGER pulse, not stored; bit1 MODE stored). Writes to other addresses are ignored.
REQ-011 SHALL run a 6-bit rate counter: env_tick = (counter >= RATE); on env_tick counter clears, else increments; RATE 0 gives env_tick every cycle.
REQ-012 SHALL implement FSM states IDLE=0, ATTACK=1, SUSTAIN=2, DECAY=3.
REQ-013 IDLE: env holds 0; TRIGGER write -> ATTACK.
REQ-014 ATTACK: on env_tick, env increments by 1; when env >= VOLUME -> SUSTAIN on the next cycle.
REQ-015 SUSTAIN: env loads VOLUME every cycle (VOLUME changes take effect in 1 cycle); if MODE=1 -> DECAY.
REQ-016 DECAY: on env_tick, env decrements by 1; when env = 0 -> IDLE.
REQ-017 TRIGGER in any state SHALL force ATTACK without clearing env (retrigger from current level); TRIGGER wins over a simultaneous env_tick (no env step that cycle).
REQ-018 env SHALL saturate at 0x3F and never wrap below 0x00.
REQ-019 level = tone_in ? env : 0, 6 bits.
REQ-020 Sigma-delta: 7-bit sum = {1'b0, acc[5:0]} + level; acc <= sum; pdm_out <= sum[6]; long-run ones density = level/64.
REQ-021 pdm_out latency: level change reflected in accumulator on the next clk edge; level 0 gives constant 0, level 0x3F gives 63 ones per 64 cycles.

Reset
REQ-022 While rst_n low: VOLUME, RATE, MODE, rate counter, env, acc = 0; state IDLE; pdm_out = 0; env_level = 0; env_state = 0.
REQ-023 Reset asserted mid-ATTACK or mid-DECAY SHALL abort immediately; first cycle after release behaves as fresh IDLE.

Structure
REQ-024 SHALL place register addresses, CTRL bit positions, and FSM state encodings in shared package yupferris_bitslam_pkg.
REQ-025 SHALL instantiate the first-order modulator as sub-module yupferris_bitslam_sdm (clk, rst_n, level[5:0] -> pdm_out).

Verification
REQ-026 VOLUME=0x10, RATE=0, TRIGGER -> env 1..16 on consecutive cycles, then env_state=2, env_level=0x10 held.
REQ-027 VOLUME=0x08, RATE=3, MODE=1, TRIGGER -> env steps every 4 cycles up to 8, one SUSTAIN cycle, decays to 0 every 4 cycles, then env_state=0.
REQ-028 tone_in=1, env held at 0x20 -> pdm_out toggles 1,0,1,0 (32 ones per 64 cycles); tone_in=0 -> pdm_out 0 after 1 cycle.
REQ-029 Retrigger during DECAY at env=5 -> env_state=1 next cycle, env continues 6,7,... with no drop to 0.
REQ-030 VOLUME lowered 0x20->0x04 in SUSTAIN -> env_level=0x04 one cycle later; write to addr 0x05 -> no register change.
REQ-031 rst_n pulsed low mid-ATTACK (async, between edges) -> all outputs 0 immediately; VOLUME reads back 0 behaviour (TRIGGER then goes ATTACK->SUSTAIN at env 0).

Source files
------------

// File: rtl/yupferris_bitslam_pkg.sv
// Shared definitions for the bitslam envelope DAC: register map, CTRL bit positions,
// envelope FSM state encodings and envelope limits.
package yupferris_bitslam_pkg;

    localparam logic [5:0] ADDR_VOLUME = 6'h01;
    localparam logic [5:0] ADDR_RATE   = 6'h02;
    localparam logic [5:0] ADDR_CTRL   = 6'h03;

    localparam int CTRL_TRIGGER_BIT = 0;
    localparam int CTRL_MODE_BIT    = 1;

    localparam logic [5:0] ENV_MAX = 6'h3F;
    localparam logic [5:0] ENV_MIN = 6'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_DECAY   = 2'd3
    } env_state_t;

endpackage

// File: rtl/yupferris_bitslam_sdm.sv
// First-order sigma-delta modulator: 6-bit level in, registered 1-bit density out.
// The carry out of the 6-bit accumulator is the output bit.
module yupferris_bitslam_sdm
    import yupferris_bitslam_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] level,
    output logic       pdm_out
);

    logic [5:0] r_acc;
    logic       r_pdm;
    logic [6:0] w_sum;

    always_comb begin
        w_sum = {1'b0, r_acc} + {1'b0, level};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_pdm <= 1'b0;
        end else begin
            r_acc <= w_sum[5:0];
            r_pdm <= w_sum[6];
        end
    end

    assign pdm_out = r_pdm;

endmodule

// File: rtl/yupferris_bitslam_envdac.sv
// Envelope generator (IDLE/ATTACK/SUSTAIN/DECAY) with a register write port, gating the
// envelope by the tone bit and driving a sigma-delta DAC for the output pin.
module yupferris_bitslam_envdac
    import yupferris_bitslam_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tone_in,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [5:0] wr_data,
    output logic       pdm_out,
    output logic [5:0] env_level,
    output logic [1:0] env_state
);

    logic [5:0] r_volume;
    logic [5:0] r_rate;
    logic       r_mode;
    logic [5:0] r_rate_cnt;
    logic [5:0] r_env;
    env_state_t r_state;

    env_state_t w_state_nxt;
    logic [5:0] w_env_nxt;
    logic       w_trigger;
    logic       w_env_tick;
    logic [5:0] w_level;

    function automatic logic [5:0] f_env_inc(input logic [5:0] v);
        return (v == ENV_MAX) ? ENV_MAX : v + 6'd1;
    endfunction

    function automatic logic [5:0] f_env_dec(input logic [5:0] v);
        return (v == ENV_MIN) ? ENV_MIN : v - 6'd1;
    endfunction

    // TRIGGER is a strobe decoded straight off the write port; it is never stored.
    assign w_trigger = wr_en && (wr_addr == ADDR_CTRL) && wr_data[CTRL_TRIGGER_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_volume <= '0;
            r_rate   <= '0;
            r_mode   <= 1'b0;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_VOLUME: r_volume <= wr_data;
                ADDR_RATE:   r_rate   <= wr_data;
                ADDR_CTRL:   r_mode   <= wr_data[CTRL_MODE_BIT];
                default:     ;
            endcase
        end
    end

    // Free-running prescaler; >= (not ==) recovers at once if RATE drops below the count.
    assign w_env_tick = (r_rate_cnt >= r_rate);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rate_cnt <= '0;
        end else if (w_env_tick) begin
            r_rate_cnt <= '0;
        end else begin
            r_rate_cnt <= r_rate_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_trigger) begin
            w_state_nxt = ST_ATTACK;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_nxt = ST_IDLE;
                ST_ATTACK:  if (r_env >= r_volume) w_state_nxt = ST_SUSTAIN;
                ST_SUSTAIN: if (r_mode) w_state_nxt = ST_DECAY;
                ST_DECAY:   if (r_env == ENV_MIN) w_state_nxt = ST_IDLE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // A trigger freezes env for its cycle so a retrigger climbs from the current level.
    always_comb begin
        w_env_nxt = r_env;
        if (!w_trigger) begin
            case (r_state)
                ST_IDLE:    w_env_nxt = ENV_MIN;
                ST_ATTACK:  if (w_env_tick && (r_env < r_volume)) w_env_nxt = f_env_inc(r_env);
                ST_SUSTAIN: w_env_nxt = r_volume;
                ST_DECAY:   if (w_env_tick) w_env_nxt = f_env_dec(r_env);
                default:    w_env_nxt = ENV_MIN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_env <= '0;
        end else begin
            r_env <= w_env_nxt;
        end
    end

    assign w_level = tone_in ? r_env : 6'd0;

    yupferris_bitslam_sdm u_sdm (
        .clk     (clk),
        .rst_n   (rst_n),
        .level   (w_level),
        .pdm_out (pdm_out)
    );

    assign env_level = r_env;
    assign env_state = r_state;

endmodule

// File: tb/tb_yupferris_bitslam_envdac.sv
// Directed bench for yupferris_bitslam_envdac: a vector table for the basic attack ramp,
// plus hand-written sequences for timing-dependent corner cases.
module tb_yupferris_bitslam_envdac;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tone_in;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [5:0] wr_data;
    logic       pdm_out;
    logic [5:0] env_level;
    logic [1:0] env_state;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       we;
        logic [5:0] addr;
        logic [5:0] data;
        logic [5:0] exp_env;
        logic [1:0] exp_st;
        logic       exp_pdm;
    } vec_t;

    vec_t vq[$];

    yupferris_bitslam_envdac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tone_in   (tone_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pdm_out   (pdm_out),
        .env_level (env_level),
        .env_state (env_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drive one cycle of write-port inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic we, input logic [5:0] a, input logic [5:0] d);
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    function automatic vec_t mk(input logic we, input logic [5:0] a, input logic [5:0] d,
                                input logic [5:0] e, input logic [1:0] s, input logic p);
        vec_t v;
        v.we = we; v.addr = a; v.data = d;
        v.exp_env = e; v.exp_st = s; v.exp_pdm = p;
        return v;
    endfunction

    initial begin
        int ones;
        int prev_pdm;
        int prev_env;
        int sus_cnt;
        int tch[$];
        int vch[$];
        bit found;

        // Attack ramp: VOLUME=0x10, RATE=0, TRIGGER, then ramp and hold in SUSTAIN.
        vq.push_back(mk(1'b1, 6'h01, 6'h10, 6'd0, 2'd0, 1'b0));
        vq.push_back(mk(1'b1, 6'h02, 6'h00, 6'd0, 2'd0, 1'b0));
        vq.push_back(mk(1'b1, 6'h03, 6'h01, 6'd0, 2'd1, 1'b0));
        for (int k = 1; k <= 16; k++)
            vq.push_back(mk(1'b0, 6'h00, 6'h00, 6'(k), 2'd1, 1'b0));
        for (int k = 0; k < 3; k++)
            vq.push_back(mk(1'b0, 6'h00, 6'h00, 6'h10, 2'd2, 1'b0));

        rst_n = 1'b0; tone_in = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_env", int'(env_level), 0);
        chk("reset_state", int'(env_state), 0);
        chk("reset_pdm", int'(pdm_out), 0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].we, vq[i].addr, vq[i].data);
            chk($sformatf("vec%0d_env", i), int'(env_level), int'(vq[i].exp_env));
            chk($sformatf("vec%0d_state", i), int'(env_state), int'(vq[i].exp_st));
            chk($sformatf("vec%0d_pdm", i), int'(pdm_out), int'(vq[i].exp_pdm));
        end

        // VOLUME changes in SUSTAIN land one cycle after the write; bad addresses ignored.
        cyc(1'b1, 6'h01, 6'h20);
        chk("vol_up_same_cycle", int'(env_level), 16);
        cyc(1'b0, 6'h00, 6'h00);
        chk("vol_up_applied", int'(env_level), 32);
        cyc(1'b1, 6'h01, 6'h04);
        chk("vol_down_same_cycle", int'(env_level), 32);
        cyc(1'b0, 6'h00, 6'h00);
        chk("vol_down_applied", int'(env_level), 4);
        cyc(1'b1, 6'h05, 6'h3F);
        cyc(1'b1, 6'h00, 6'h3F);
        cyc(1'b0, 6'h00, 6'h00);
        cyc(1'b0, 6'h00, 6'h00);
        chk("bad_addr_env", int'(env_level), 4);
        chk("bad_addr_state", int'(env_state), 2);

        // Half-scale level: strict alternation, 32 ones in 64 cycles.
        cyc(1'b1, 6'h01, 6'h20);
        cyc(1'b0, 6'h00, 6'h00);
        chk("half_env", int'(env_level), 32);
        tone_in = 1'b1;
        ones = 0;
        prev_pdm = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 6'h00, 6'h00);
            if (i > 0) chk($sformatf("half_toggle%0d", i), int'(pdm_out), 1 - prev_pdm);
            prev_pdm = int'(pdm_out);
            ones += int'(pdm_out);
        end
        chk("half_ones", ones, 32);
        tone_in = 1'b0;
        cyc(1'b0, 6'h00, 6'h00);
        chk("tone_off_pdm", int'(pdm_out), 0);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 6'h00, 6'h00);
            ones += int'(pdm_out);
        end
        chk("tone_off_ones", ones, 0);

        // Full-scale level: 63 ones per 64 cycles.
        cyc(1'b1, 6'h01, 6'h3F);
        tone_in = 1'b1;
        cyc(1'b0, 6'h00, 6'h00);
        chk("full_env", int'(env_level), 63);
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 6'h00, 6'h00);
            ones += int'(pdm_out);
        end
        chk("full_ones", ones, 63);
        tone_in = 1'b0;

        // Synchronous-looking reset pulse back to a clean start.
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset2_env", int'(env_level), 0);
        chk("reset2_state", int'(env_state), 0);
        #2 rst_n = 1'b1;

        // VOLUME=8, RATE=3, MODE=1: steps every 4 cycles up and down, one SUSTAIN cycle.
        cyc(1'b1, 6'h01, 6'h08);
        cyc(1'b1, 6'h02, 6'h03);
        cyc(1'b1, 6'h03, 6'h03);
        chk("adsr_trig_state", int'(env_state), 1);
        prev_env = int'(env_level);
        sus_cnt = 0;
        for (int t = 0; t < 200 && vch.size() < 16; t++) begin
            cyc(1'b0, 6'h00, 6'h00);
            if (env_state == 2'd2) sus_cnt++;
            if (int'(env_level) != prev_env) begin
                tch.push_back(t);
                vch.push_back(int'(env_level));
                prev_env = int'(env_level);
            end
        end
        chk("adsr_changes", vch.size(), 16);
        for (int i = 0; i < vch.size(); i++) begin
            chk($sformatf("adsr_val%0d", i), vch[i], (i < 8) ? i + 1 : 15 - i);
            if (i > 0) chk($sformatf("adsr_gap%0d", i), tch[i] - tch[i-1], 4);
        end
        chk("adsr_sustain_cycles", sus_cnt, 1);
        cyc(1'b0, 6'h00, 6'h00);
        chk("adsr_end_state", int'(env_state), 0);
        chk("adsr_end_env", int'(env_level), 0);

        // Retrigger during DECAY at env=5 resumes climbing from 5.
        cyc(1'b1, 6'h02, 6'h00);
        cyc(1'b1, 6'h03, 6'h03);
        found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            cyc(1'b0, 6'h00, 6'h00);
            if (env_level == 6'd5 && env_state == 2'd3) found = 1'b1;
        end
        chk("retrig_reached_decay5", int'(found), 1);
        cyc(1'b1, 6'h03, 6'h03);
        chk("retrig_state", int'(env_state), 1);
        chk("retrig_env_hold", int'(env_level), 5);
        cyc(1'b0, 6'h00, 6'h00);
        chk("retrig_env6", int'(env_level), 6);
        cyc(1'b0, 6'h00, 6'h00);
        chk("retrig_env7", int'(env_level), 7);
        chk("retrig_state7", int'(env_state), 1);

        // Asynchronous reset between edges mid-ATTACK clears everything at once.
        tone_in = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_env", int'(env_level), 0);
        chk("async_rst_state", int'(env_state), 0);
        chk("async_rst_pdm", int'(pdm_out), 0);
        #1 rst_n = 1'b1;
        tone_in = 1'b0;
        cyc(1'b1, 6'h03, 6'h01);
        chk("post_rst_trig_state", int'(env_state), 1);
        chk("post_rst_trig_env", int'(env_level), 0);
        cyc(1'b0, 6'h00, 6'h00);
        chk("post_rst_sustain", int'(env_state), 2);
        chk("post_rst_env", int'(env_level), 0);
        cyc(1'b0, 6'h00, 6'h00);
        chk("post_rst_hold", int'(env_state), 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
